// File: rtl/fifo_spi_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_spi_reader_if
//   Bundles the SPI pins and the FIFO read port seen by fifo_spi_reader.
//
//   Signals
//     spi_sclk     SPI clock from the Pi, idle low (mode 0)
//     spi_cs_n     SPI chip select, active low
//     spi_miso     serial data to the Pi
//     spi_miso_oe  output enable for the top-level tristate
//     fifo_read    FIFO pop strobe, one clk cycle
//     fifo_data    FIFO read data, valid the cycle after fifo_read
//     fifo_empty   FIFO empty flag
//
//   Modports
//     slave   the reader (SPI slave, FIFO consumer)
//     master  the environment: Pi-side pins and the FIFO
// ---------------------------------------------------------------------------
interface fifo_spi_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  spi_sclk;
  logic                  spi_cs_n;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;

  modport slave (
    input  spi_sclk, spi_cs_n, fifo_data, fifo_empty,
    output spi_miso, spi_miso_oe, fifo_read
  );

  modport master (
    output spi_sclk, spi_cs_n, fifo_data, fifo_empty,
    input  spi_miso, spi_miso_oe, fifo_read
  );
endinterface

// File: rtl/fifo_spi_reader.sv
// ---------------------------------------------------------------------------
// fifo_spi_reader
//   Pops samples from the ADC sample FIFO and shifts them out MSB-first to
//   the Raspberry Pi over a read-only SPI mode-0 slave link. The SPI pins are
//   synchronized and edge-detected in the clk domain. A one-word prefetch
//   buffer hides the FIFO read latency so words stream back-to-back inside
//   one chip-select window.
//
//   Parameters
//     DATA_WIDTH      sample width and SPI word length (16)
//     SYNC_STAGES     synchronizer depth on spi_sclk / spi_cs_n (>= 2)
//     UNDERFLOW_WORD  word shifted out when no sample is available
//
//   Ports
//     clk            system clock, at least 8x spi_sclk
//     rst            synchronous, active-low reset
//     bus            fifo_spi_reader_if.slave (SPI pins + FIFO read port)
//     underflow_cnt  saturating underflow event counter (macro only)
//
//   Optional feature
//     FIFO_SPI_UNDERFLOW_CNT_EN  adds the underflow_cnt port and counter
// ---------------------------------------------------------------------------
module fifo_spi_reader #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    SYNC_STAGES    = 2,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_WORD = '0
) (
  input  logic             clk,
  input  logic             rst,
  fifo_spi_reader_if.slave bus
`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]      underflow_cnt
`endif
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] WORD_END = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    PF_EMPTY,    // no word held; pop when the FIFO has one
    PF_READ,     // pop strobe on the wire, data not yet valid
    PF_CAPTURE,  // fifo_data valid this cycle
    PF_FULL      // pbuf holds a word waiting for the shifter
  } pf_state_t;

  typedef enum logic {
    SH_IDLE,
    SH_SHIFT
  } sh_state_t;

  // -------------------------------------------------------------------------
  // Pin synchronizers and edge detection.
  // Reset values match the idle bus (sclk low, cs_n high) so leaving reset
  // never fabricates an edge.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours, which is what a shift chain needs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_prev;
  assign cs_rise   =  cs_sync[SYNC_STAGES-1]   & ~cs_prev;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1]   &  cs_prev;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  pf_state_t             pf_state;
  sh_state_t             sh_state;
  logic [DATA_WIDTH-1:0] pbuf;
  logic                  pvalid;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bitcnt;

  // -------------------------------------------------------------------------
  // Word load / consume decision.
  // A chip-select rise wins over a coincident sclk fall, so a Pi that drops
  // sclk and raises cs_n together ends the window without pulling another
  // word. A word in CAPTURE is handed straight to the shifter.
  // -------------------------------------------------------------------------
  logic                  load_word;
  logic                  take_capture;
  logic                  take_pbuf;
  logic [DATA_WIDTH-1:0] next_word;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    load_word    = 1'b0;
    take_capture = 1'b0;
    take_pbuf    = 1'b0;
    next_word    = UNDERFLOW_WORD;

    if (sh_state == SH_IDLE)
      load_word = cs_fall;
    else
      load_word = !cs_rise && sclk_fall && (bitcnt == WORD_END);

    if (pf_state == PF_CAPTURE) begin
      take_capture = load_word;
      next_word    = bus.fifo_data;
    end else if (pvalid) begin
      take_pbuf = load_word;
      next_word = pbuf;
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch FSM: keeps one FIFO word ready in pbuf, at most one read in
  // flight, never pops an empty FIFO.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pf_state      <= PF_EMPTY;
      pbuf          <= '0;
      pvalid        <= 1'b0;
      bus.fifo_read <= 1'b0;
    end else begin
      bus.fifo_read <= 1'b0;
      case (pf_state)
        PF_EMPTY: begin
          if (!bus.fifo_empty) begin
            bus.fifo_read <= 1'b1;
            pf_state      <= PF_READ;
          end
        end
        PF_READ: begin
          pf_state <= PF_CAPTURE;
        end
        PF_CAPTURE: begin
          pbuf <= bus.fifo_data;
          if (take_capture) begin
            pvalid   <= 1'b0;
            pf_state <= PF_EMPTY;
          end else begin
            pvalid   <= 1'b1;
            pf_state <= PF_FULL;
          end
        end
        PF_FULL: begin
          if (take_pbuf) begin
            pvalid   <= 1'b0;
            pf_state <= PF_EMPTY;
          end
        end
        default: pf_state <= PF_EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Shift FSM. The Pi samples on sclk rise; the next bit is presented on
  // sclk fall. After DATA_WIDTH rises, the fall loads the next word.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_state        <= SH_IDLE;
      shreg           <= '0;
      bitcnt          <= '0;
      bus.spi_miso_oe <= 1'b0;
    end else begin
      case (sh_state)
        SH_IDLE: begin
          if (cs_fall) begin
            shreg           <= next_word;
            bitcnt          <= '0;
            bus.spi_miso_oe <= 1'b1;
            sh_state        <= SH_SHIFT;
          end
        end
        SH_SHIFT: begin
          if (cs_rise) begin
            // Any partial word is dropped; it was consumed at load time.
            bitcnt          <= '0;
            bus.spi_miso_oe <= 1'b0;
            sh_state        <= SH_IDLE;
          end else if (sclk_rise) begin
            if (bitcnt != WORD_END)
              bitcnt <= bitcnt + CNT_W'(1);
          end else if (sclk_fall) begin
            if (bitcnt == WORD_END) begin
              shreg  <= next_word;
              bitcnt <= '0;
            end else begin
              shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: sh_state <= SH_IDLE;
      endcase
    end
  end

  assign bus.spi_miso = shreg[DATA_WIDTH-1];

  // -------------------------------------------------------------------------
  // Optional saturating underflow counter, cleared only by reset.
  // -------------------------------------------------------------------------
`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
  logic        underflow;
  logic [15:0] underflow_q;

  assign underflow = load_word && !take_capture && !take_pbuf;

  always_ff @(posedge clk) begin
    if (!rst)
      underflow_q <= '0;
    else if (underflow && (underflow_q != 16'hFFFF))
      underflow_q <= underflow_q + 16'd1;
  end

  assign underflow_cnt = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_spi_reader
//   Directed bench for fifo_spi_reader: a small FIFO model with registered
//   read port, a mode-0 SPI master driven from one initial block, and
//   hand-computed expected words. Counter checks exist only when
//   FIFO_SPI_UNDERFLOW_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_fifo_spi_reader;

  logic clk;
  logic rst;

  fifo_spi_reader_if #(.DATA_WIDTH(16)) bus ();

`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  fifo_spi_reader #(
    .DATA_WIDTH     (16),
    .SYNC_STAGES    (2),
    .UNDERFLOW_WORD (16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [15:0] fifo_mem [16];
  int          wr_ptr;
  int          rd_ptr;
  int          read_pulses;
  int          bad_reads;

  initial begin
    rd_ptr      = 0;
    read_pulses = 0;
    bad_reads   = 0;
  end

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.fifo_read) begin
      read_pulses <= read_pulses + 1;
      if (bus.fifo_empty)
        bad_reads <= bad_reads + 1;
      else begin
        bus.fifo_data <= fifo_mem[rd_ptr % 16];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  // Mode-0 master: cs_n low, nbits clocks with 4-cycle phases, MISO sampled
  // at each rise. With close set, cs_n rises together with the last fall.
  task automatic xfer(input int nbits, input bit close,
                      output logic [31:0] rx, output logic oe_mid);
    rx     = '0;
    oe_mid = 1'b0;
    bus.spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      tick(4);
      rx = {rx[30:0], bus.spi_miso};
      if (i == 0) oe_mid = bus.spi_miso_oe;
      bus.spi_sclk = 1'b1;
      tick(4);
      bus.spi_sclk = 1'b0;
      if (close && (i == nbits - 1)) bus.spi_cs_n = 1'b1;
    end
    if (close) begin
      if (nbits == 0) begin
        tick(4);
        bus.spi_cs_n = 1'b1;
      end
      tick(8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rx;
    logic        oe_mid;
    int          base;

    n_cmp        = 0;
    n_bad        = 0;
    wr_ptr       = 0;
    rst          = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(2);

    // Reset state
    check("rst_miso",   32'(bus.spi_miso),    32'd0);
    check("rst_oe",     32'(bus.spi_miso_oe), 32'd0);
    check("rst_read",   32'(bus.fifo_read),   32'd0);
    check("rst_pvalid", 32'(dut.pvalid),      32'd0);
`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
    check("rst_ucnt",   32'(underflow_cnt),   32'd0);
`endif

    // Single word A5C3
    base = read_pulses;
    push(16'hA5C3);
    tick(4);
    check("t1_pvalid", 32'(dut.pvalid), 32'd1);
    xfer(16, 1'b1, rx, oe_mid);
    check("t1_word",   rx,                      32'h0000A5C3);
    check("t1_oe_mid", 32'(oe_mid),             32'd1);
    check("t1_oe_end", 32'(bus.spi_miso_oe),    32'd0);
    check("t1_reads",  32'(read_pulses - base), 32'd1);

    // Back-to-back burst 1234, 5678
    base = read_pulses;
    push(16'h1234);
    push(16'h5678);
    tick(4);
    xfer(32, 1'b1, rx, oe_mid);
    check("t2_burst", rx,                      32'h12345678);
    check("t2_reads", 32'(read_pulses - base), 32'd2);
    check("t2_empty", 32'(bus.fifo_empty),     32'd1);

    // Underflow on empty FIFO
    base = read_pulses;
    xfer(16, 1'b1, rx, oe_mid);
    check("t3_word",  rx,                      32'h00000000);
    check("t3_reads", 32'(read_pulses - base), 32'd0);
`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
    check("t3_ucnt",  32'(underflow_cnt),      32'd1);
`endif

    // Abort after 5 bits; the rest of AAAA must not be resent
    base = read_pulses;
    push(16'hAAAA);
    push(16'h0F0F);
    tick(4);
    xfer(5, 1'b1, rx, oe_mid);
    check("t4_partial", rx, 32'h00000015);
    xfer(16, 1'b1, rx, oe_mid);
    check("t4_next",  rx,                      32'h00000F0F);
    check("t4_reads", 32'(read_pulses - base), 32'd2);

    // Reset during bit 8 with pbuf holding 2222
    base = read_pulses;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    tick(6);
    xfer(7, 1'b0, rx, oe_mid);
    tick(4);
    bus.spi_sclk = 1'b1;
    tick(2);
    check("t5_pvalid_pre", 32'(dut.pvalid), 32'd1);
    rst          = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    tick(3);
    rst = 1'b1;
    check("t5_miso",   32'(bus.spi_miso),    32'd0);
    check("t5_oe",     32'(bus.spi_miso_oe), 32'd0);
    check("t5_pvalid", 32'(dut.pvalid),      32'd0);
`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
    check("t5_ucnt",   32'(underflow_cnt),   32'd0);
`endif
    tick(4);
    xfer(16, 1'b1, rx, oe_mid);
    check("t5_next",  rx,                      32'h00003333);
    check("t5_reads", 32'(read_pulses - base), 32'd3);

`ifdef FIFO_SPI_UNDERFLOW_CNT_EN
    // Saturation: preload near the top instead of 65540 real transactions
    force dut.underflow_q = 16'hFFFC;
    tick(1);
    release dut.underflow_q;
    repeat (2) xfer(0, 1'b1, rx, oe_mid);
    check("t6_ucnt_fffe", 32'(underflow_cnt), 32'h0000FFFE);
    repeat (3) xfer(0, 1'b1, rx, oe_mid);
    check("t6_ucnt_sat",  32'(underflow_cnt), 32'h0000FFFF);
`endif

    check("no_read_when_empty", 32'(bad_reads), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
